// File: rtl/total_alu_pkg.sv
// Shared constants and types for the total_alu datapath.
package total_alu_pkg;

    localparam int unsigned WIDTH = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        SLICE_AND  = 2'b00,
        SLICE_OR   = 2'b01,
        SLICE_SUM  = 2'b10,
        SLICE_LESS = 2'b11
    } slice_op_e;

endpackage

// File: rtl/total_alu_bit_slice.sv
// One-bit ALU slice; set/overflow are meaningful only on the MSB slice.
module alu_bit_slice
    import total_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       less,
    input  logic       binvert,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout,
    output logic       set,
    output logic       overflow
);

    logic w_b;
    logic w_sum;

    assign w_b      = b ^ binvert;
    assign w_sum    = a ^ w_b ^ cin;
    assign cout     = (a & w_b) | (a & cin) | (w_b & cin);
    // Signed overflow is the carry into the sign bit differing from the carry out.
    assign overflow = cin ^ cout;
    assign set      = w_sum ^ overflow;

    always_comb begin
        result = 1'b0;
        case (slice_op_e'(op))
            SLICE_AND:  result = a & w_b;
            SLICE_OR:   result = a | w_b;
            SLICE_SUM:  result = w_sum;
            SLICE_LESS: result = less;
            default:    result = 1'b0;
        endcase
    end

endmodule

// File: rtl/total_alu.sv
// 4-bit registered ALU built from ripple-connected 1-bit slices.
module total_alu
    import total_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       signal,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_slice_res;
    logic             w_set;
    logic             w_msb_ovf;
    logic [WIDTH-2:0] w_unused_set;
    logic [WIDTH-2:0] w_unused_ovf;

    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_ovf;

    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;

    assign w_c[0] = signal[2];

    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_slice
        alu_bit_slice u_slice (
            .a        (a[gi]),
            .b        (b[gi]),
            .less     ((gi == 0) ? w_set : 1'b0),
            .binvert  (signal[2]),
            .cin      (w_c[gi]),
            .op       (signal[1:0]),
            .result   (w_slice_res[gi]),
            .cout     (w_c[gi+1]),
            .set      (w_unused_set[gi]),
            .overflow (w_unused_ovf[gi])
        );
    end

    alu_bit_slice u_msb (
        .a        (a[WIDTH-1]),
        .b        (b[WIDTH-1]),
        .less     (1'b0),
        .binvert  (signal[2]),
        .cin      (w_c[WIDTH-1]),
        .op       (signal[1:0]),
        .result   (w_slice_res[WIDTH-1]),
        .cout     (w_c[WIDTH]),
        .set      (w_set),
        .overflow (w_msb_ovf)
    );

    // Reserved codes would otherwise leak slice results (e.g. 011 acts like SLT).
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (signal)
            OP_AND, OP_OR, OP_SLT: begin
                w_result = w_slice_res;
            end
            OP_ADD, OP_SUB: begin
                w_result = w_slice_res;
                w_carry  = w_c[WIDTH];
                w_ovf    = w_msb_ovf;
            end
            default: begin
                w_result = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_out   <= w_result;
            r_zero  <= (w_result == '0);
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end
    end

    assign out      = r_out;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_total_alu.sv
// Directed-vector bench for total_alu; expected values are {out, zero, carry, overflow}.
module tb_total_alu;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] signal;
    logic [3:0] out;
    logic       zero;
    logic       carry;
    logic       overflow;

    int unsigned n_checks;
    int unsigned n_pass;

    total_alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .signal   (signal),
        .out      (out),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got out=%b z=%b c=%b v=%b, expected out=%b z=%b c=%b v=%b",
                     tag, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Apply inputs, clock once, then compare the registered result.
    task automatic run(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic [2:0] ts, input logic [6:0] exp);
        a      = ta;
        b      = tb;
        signal = ts;
        @(posedge clk);
        #1;
        check(tag, {out, zero, carry, overflow}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        a        = 4'b1111;
        b        = 4'b1111;
        signal   = 3'b010;

        @(posedge clk); #1;
        check("reset1", {out, zero, carry, overflow}, 7'b0000_000);
        @(posedge clk); #1;
        check("reset2", {out, zero, carry, overflow}, 7'b0000_000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("release", {out, zero, carry, overflow}, 7'b1110_010);

        run("and1", 4'b1110, 4'b0101, 3'b000, 7'b0100_000);
        run("and2", 4'b0110, 4'b0100, 3'b000, 7'b0100_000);
        run("or1",  4'b1011, 4'b0000, 3'b001, 7'b1011_000);
        run("or2",  4'b1010, 4'b1000, 3'b001, 7'b1010_000);

        run("add1", 4'b0010, 4'b1100, 3'b010, 7'b1110_000);
        run("add2", 4'b1000, 4'b1111, 3'b010, 7'b0111_011);
        run("add3", 4'b1000, 4'b0001, 3'b010, 7'b1001_000);
        run("add4", 4'b0111, 4'b0001, 3'b010, 7'b1000_001);

        run("sub1", 4'b1011, 4'b0010, 3'b110, 7'b1001_010);
        run("sub2", 4'b0110, 4'b0111, 3'b110, 7'b1111_000);
        run("sub3", 4'b0101, 4'b0101, 3'b110, 7'b0000_110);
        run("sub4", 4'b1000, 4'b0001, 3'b110, 7'b0111_011);

        run("slt1", 4'b0010, 4'b0101, 3'b111, 7'b0001_000);
        run("slt2", 4'b0101, 4'b0010, 3'b111, 7'b0000_100);
        run("slt3", 4'b1000, 4'b0001, 3'b111, 7'b0001_000);
        run("slt4", 4'b0111, 4'b1000, 3'b111, 7'b0000_100);

        run("rsv100", 4'b1111, 4'b0000, 3'b100, 7'b0000_100);
        run("rsv011", 4'b0010, 4'b0101, 3'b011, 7'b0000_100);
        run("rsv101", 4'b1111, 4'b0000, 3'b101, 7'b0000_100);

        // Outputs must hold while inputs change between edges.
        run("hold_pre", 4'b1011, 4'b0010, 3'b110, 7'b1001_010);
        a      = 4'b0001;
        b      = 4'b0001;
        signal = 3'b010;
        #3;
        check("hold", {out, zero, carry, overflow}, 7'b1001_010);

        // Mid-stream reset discards the in-flight result.
        rst = 1'b1;
        run("midrst", 4'b0011, 4'b0100, 3'b010, 7'b0000_000);
        rst = 1'b0;
        run("postrst", 4'b0011, 4'b0100, 3'b010, 7'b0111_000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/total_alu.md
# total_alu

4-bit registered ALU performing AND, OR, ADD, SUB and signed set-less-than (SLT) on two operands, selected by a 3-bit operation code. It is the execution datapath for a small MIPS-style core. Combinational logic is built from four ripple-connected 1-bit ALU slices. Result and status flags are captured in an output register on the clock edge.

## Interface
- No parameters; data width fixed at 4 bits.
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- a  input  4  operand A (two's complement for ADD/SUB/SLT)
- b  input  4  operand B
- signal  input  3  operation select: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- out  output  4  registered result
- zero  output  1  registered; 1 when the result is 0000
- carry  output  1  registered carry-out of the MSB slice (ADD/SUB only, else 0)
- overflow  output  1  registered signed overflow (ADD/SUB only, else 0)

## Operation
- Decode: binvert = signal[2]; slice carry-in to bit 0 = signal[2]; op = signal[1:0] (00 AND, 01 OR, 10 SUM, 11 LESS).
- AND: out = a & b. OR: out = a | b.
- ADD: out = (a + b) mod 16; carry = bit 4 of the 5-bit sum; overflow = (a[3] == b[3]) && (sum[3] != a[3]).
- SUB: out = (a + ~b + 1) mod 16; carry = carry-out (1 means no borrow); overflow = (a[3] != b[3]) && (diff[3] != a[3]).
- SLT (signed): out = {3'b000, set}, where set = diff[3] XOR overflow_sub for a - b. Bits [3:1] are 0. carry and overflow report 0.
- Reserved codes 011, 100 and 101 produce out = 0000, zero = 1, carry = 0, overflow = 0.
- zero is derived from the final selected 4-bit result for every code.

## Timing
- Fully synchronous. On each rising clk edge the registers load the combinational result of the current a, b and signal.
- Latency is 1 cycle: inputs present before edge N appear on out/flags after edge N. New inputs are accepted every cycle; there is no handshake.
- Reset: when rst = 1 at the edge, out = 0000, zero = 0, carry = 0, overflow = 0. Reset takes priority over the computed result.
- Reset asserted mid-stream discards the in-flight result. The first edge with rst = 0 loads the current inputs' result.
- Outputs hold their value between edges. Input changes between edges have no effect on the outputs.

## Structure
- Shared package total_alu_pkg holds:
  - localparams for the opcodes (OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b110, OP_SLT = 3'b111);
  - the slice op enum (AND, OR, SUM, LESS);
  - WIDTH = 4.
- Sub-module alu_bit_slice: inputs a, b, less, binvert, cin, op[1:0]; outputs result, cout. The MSB slice also outputs set and overflow.
- The top level instantiates 4 slices. It wires set from the MSB slice to the less input of bit 0, ties less of bits 1-3 to 0, decodes reserved codes, and holds the output register and flag logic.

## Test plan
- Reset: rst = 1 for 2 cycles with a = 1111, b = 1111, signal = 010 -> out = 0000 and all flags 0. Release rst -> next edge gives out = 1110, carry = 1, overflow = 0.
- AND/OR:
  - 1110 & 0101 -> 0100.
  - 0110 & 0100 -> 0100.
  - 1011 | 0000 -> 1011.
  - 1010 | 1000 -> 1010.
  - Each result appears one cycle after its inputs.
- ADD:
  - 0010 + 1100 -> 1110, carry 0, overflow 0.
  - 1000 + 1111 -> 0111, carry 1, overflow 1.
  - 1000 + 0001 -> 1001, no flags.
- SUB:
  - 1011 - 0010 -> 1001, carry 1, overflow 0.
  - 0110 - 0111 -> 1111, carry 0.
  - 0101 - 0101 -> 0000, zero = 1.
- SLT:
  - 0010 vs 0101 -> 0001.
  - 0101 vs 0010 -> 0000.
  - 1000 vs 0001 -> 0001 (signed, overflow-corrected).
  - 0111 vs 1000 -> 0000.
- Reserved code 100 with a = 1111, b = 0000 -> out = 0000, zero = 1. Back-to-back opcode changes every cycle produce the correct result stream with 1-cycle latency.
